// File: rtl/qsic_pkg.sv
// Shared QBUS interrupt types and constants.
// FSM state encoding, vector width and default vector base.
package qsic_pkg;

  localparam int VEC_W = 9;
  localparam int IDX_W = 3;

  localparam logic [VEC_W-1:0] VEC_DEF_BASE = 9'o300;
  localparam logic [VEC_W-1:0] VEC_MAX      = 9'o774;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_HOLD = 2'd2
  } qirq_state_e;

  function automatic logic [VEC_W-1:0] vec_of(
    input logic [VEC_W-1:0] base,
    input logic [IDX_W-1:0] idx
  );
    return base + {{(VEC_W-IDX_W-2){1'b0}}, idx, 2'b00};
  endfunction

endpackage

// File: rtl/qirq_sched_if.sv
// Bus-interface side of the interrupt scheduler.
// master = scheduler, slave = QBUS interface logic.
interface qirq_bus_if;
  import qsic_pkg::*;

  logic             assert_vector;
  logic             interrupt_cycle;
  logic             irq_assert;
  logic [VEC_W-1:0] vector;

  modport master (
    input  assert_vector,
    input  interrupt_cycle,
    output irq_assert,
    output vector
  );

  modport slave (
    output assert_vector,
    output interrupt_cycle,
    input  irq_assert,
    input  vector
  );

endinterface

// File: rtl/qirq_prio.sv
// Fixed-priority encoder: lowest set index wins.
// Purely combinational, reusable by other arbiters.
module qirq_prio
  import qsic_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]     req,
  output logic             valid,
  output logic [IDX_W-1:0] idx
);

  always_comb begin
    valid = 1'b0;
    idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        valid = 1'b1;
        idx   = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/qirq_sched.sv
// QBUS interrupt scheduler: edge-latched pending requests,
// fixed-priority grant, registered vector and ack pulse.
module qirq_sched
  import qsic_pkg::*;
#(
  parameter int               NSRC     = 4,
  parameter logic [VEC_W-1:0] VEC_BASE = VEC_DEF_BASE
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NSRC-1:0] req_level,
  input  logic [NSRC-1:0] req_enable,
  qirq_bus_if.master      bus,
  output logic [NSRC-1:0] pending,
  output logic [NSRC-1:0] ack_src
);

  qirq_state_e      state, state_n;
  logic [IDX_W-1:0] grant, grant_n;
  logic [VEC_W-1:0] vec_q, vec_n;
  logic             irq_q;

  logic [NSRC-1:0]  trig, trig_d, rise;
  logic [NSRC-1:0]  clr, pend_n;
  logic [NSRC-1:0]  gmask, ack_vec;
  logic             gnt_pend, do_ack;
  logic             pv;
  logic [IDX_W-1:0] pidx;

  assign trig = req_level & req_enable;
  assign rise = trig & ~trig_d;

  qirq_prio #(.N(NSRC)) u_prio (
    .req   (pending),
    .valid (pv),
    .idx   (pidx)
  );

  always_comb begin
    gmask = '0;
    for (int i = 0; i < NSRC; i++) begin
      gmask[i] = (grant == IDX_W'(i));
    end
  end

  assign gnt_pend = |(pending & gmask);

  always_comb begin
    state_n = state;
    grant_n = grant;
    vec_n   = vec_q;
    do_ack  = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (pv) begin
          state_n = ST_REQ;
          grant_n = pidx;
          vec_n   = vec_of(VEC_BASE, pidx);
        end
      end
      ST_REQ: begin
        if (bus.interrupt_cycle) begin
          do_ack  = 1'b1;
          state_n = ST_HOLD;
        end else if (!gnt_pend && !bus.assert_vector) begin
          state_n = ST_IDLE;
        end
      end
      ST_HOLD: begin
        if (!bus.assert_vector) begin
          state_n = ST_IDLE;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // A fresh edge in the ack cycle re-arms the request.
  assign ack_vec = gmask & {NSRC{do_ack}};
  assign clr     = ~req_enable | ack_vec;
  assign pend_n  = rise | (pending & ~clr);

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      grant   <= '0;
      vec_q   <= VEC_BASE;
      irq_q   <= 1'b0;
      trig_d  <= '0;
      pending <= '0;
      ack_src <= '0;
    end else begin
      state   <= state_n;
      grant   <= grant_n;
      vec_q   <= vec_n;
      irq_q   <= (state_n == ST_REQ);
      trig_d  <= trig;
      pending <= pend_n;
      ack_src <= ack_vec;
    end
  end

  assign bus.irq_assert = irq_q;
  assign bus.vector     = vec_q;

endmodule
